// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter : two-master round-robin arbiter for one Avalon-MM SDRAM port
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sdram_port_arbiter #(
    parameter int ADDR_W          = 24,
    parameter int DATA_W          = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int HOLD_MAX        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_read,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic              s_read,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,
    output logic [1:0]        owner,
    output logic [2:0]        rd_pending,
    output logic              err_unexpected_rdv
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    state_t                     state_q;
    logic                       last_q;     // 0 = m0 owned last, 1 = m1
    logic [7:0]                 hold_q;
    logic [MAX_OUTSTANDING-1:0] ids_q;
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [2:0]                 cnt_q;
    logic                       err_q;

    logic              w_own, w_id, w_req0, w_req1, w_sel_req, w_oth_req;
    logic              w_mwr, w_mrd, w_full, w_rd_blk, w_accept, w_push, w_pop;
    logic              w_release, w_wait_sel;
    logic [ADDR_W-1:0] w_maddr;
    logic [DATA_W-1:0] w_mwdata;
    logic [7:0]        w_hold_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_own     = (state_q != ST_IDLE);
        w_id      = (state_q == ST_OWN1);
        w_req0    = m0_read | m0_write;
        w_req1    = m1_read | m1_write;
        w_sel_req = w_id ? w_req1 : w_req0;
        w_oth_req = w_id ? w_req0 : w_req1;
        w_mwr     = w_id ? m1_write : m0_write;
        w_mrd     = w_id ? m1_read  : m0_read;
        w_maddr   = w_id ? m1_address : m0_address;
        w_mwdata  = w_id ? m1_writedata : m0_writedata;
        w_full    = (cnt_q == 3'(MAX_OUTSTANDING));
        // A full routing FIFO blocks reads even when a pop lands this cycle
        w_rd_blk  = w_mrd & ~w_mwr & w_full;
        s_write   = w_own & w_mwr;
        s_read    = w_own & w_mrd & ~w_mwr & ~w_full;
        s_address   = w_own ? w_maddr : '0;
        s_writedata = w_own ? w_mwdata : '0;
        w_accept  = (s_write | s_read) & ~s_waitrequest;
        w_push    = w_accept & s_read;
        w_pop     = s_readdatavalid & (cnt_q != 3'd0);
        w_wait_sel = s_waitrequest | w_rd_blk;
        m0_waitrequest = (state_q == ST_OWN0) ? w_wait_sel : 1'b1;
        m1_waitrequest = (state_q == ST_OWN1) ? w_wait_sel : 1'b1;
        w_hold_nxt = (w_accept && hold_q != 8'(HOLD_MAX)) ? hold_q + 8'd1 : hold_q;
        // Release only when nothing is left stalled on the port
        w_release = w_own & ~(w_sel_req & ~w_accept)
                  & (~w_sel_req | ((w_hold_nxt == 8'(HOLD_MAX)) & w_oth_req));
    end

    assign m0_readdata        = s_readdata;
    assign m1_readdata        = s_readdata;
    assign m0_readdatavalid   = w_pop & ~ids_q[rd_ptr_q];
    assign m1_readdatavalid   = w_pop &  ids_q[rd_ptr_q];
    assign owner              = state_q;
    assign rd_pending         = cnt_q;
    assign err_unexpected_rdv = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_req0 && (!w_req1 || last_q))
                        state_q <= ST_OWN0;
                    else if (w_req1)
                        state_q <= ST_OWN1;
                end
                default: begin
                    if (w_release) begin
                        last_q  <= w_id;
                        hold_q  <= '0;
                        state_q <= w_oth_req ? (w_id ? ST_OWN0 : ST_OWN1) : ST_IDLE;
                    end else begin
                        hold_q  <= w_hold_nxt;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (w_push) begin
                ids_q[wr_ptr_q] <= w_id;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (w_pop)
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (w_push && !w_pop)
                cnt_q <= cnt_q + 3'd1;
            else if (!w_push && w_pop)
                cnt_q <= cnt_q - 3'd1;
            if (s_readdatavalid && cnt_q == 3'd0)
                err_q <= 1'b1;
        end
    end

endmodule

`default_nettype wire
